// File: rtl/uart_tx_module.sv
// rtl/uart_tx_module.sv - UART transmitter with a one-byte holding register
// Bit timing runs off the 16x-baud tick; STOP chains straight into START when a byte is waiting.
module uart_tx_module #(
  parameter bit PARITY_EN  = 1'b1,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_16bd,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       ack,
  output logic       Tx,
  output logic       busy,
  output logic [8:0] frame_out
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic STOP_LAST = (STOP_BITS == 2);

  state_t     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q;
  logic       hold_full_q, hold_full_d;
  logic [8:0] frame_q, frame_d;
  logic       tx_q, tx_d;
  logic       ack_q;
  logic       capture;
  logic       load;
  logic       par;

  // Capture is decided on the flag as it stood at the start of the cycle.
  assign capture = data_valid && !hold_full_q;
  assign par     = PARITY_EN ? (PARITY_ODD ? ~^hold_q : ^hold_q) : 1'b0;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shift_d     = shift_q;
    frame_d     = frame_q;
    load        = 1'b0;
    if (tick_16bd) begin
      case (state_q)
        IDLE: begin
          if (hold_full_q) load = 1'b1;
        end
        START: begin
          if (tick_cnt_q == 4'd15) begin
            state_d    = DATA;
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        DATA: begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = 4'd0;
            shift_d    = {1'b0, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_d    = PARITY_EN ? PARITY : STOP;
              stop_cnt_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        PARITY: begin
          if (tick_cnt_q == 4'd15) begin
            state_d    = STOP;
            tick_cnt_d = 4'd0;
            stop_cnt_d = 1'b0;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        STOP: begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = 4'd0;
            if (stop_cnt_q == STOP_LAST) begin
              if (hold_full_q) load = 1'b1;
              else             state_d = IDLE;
            end else begin
              stop_cnt_d = stop_cnt_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (load) begin
      state_d    = START;
      tick_cnt_d = 4'd0;
      shift_d    = hold_q;
      frame_d    = {par, hold_q};
    end
  end

  always_comb begin
    hold_full_d = hold_full_q;
    if (load)    hold_full_d = 1'b0;
    if (capture) hold_full_d = 1'b1;
  end

  // Tx is driven from the next-state so the line moves on the qualifying tick edge.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = frame_d[8];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      stop_cnt_q  <= 1'b0;
      shift_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
      frame_q     <= 9'd0;
      tx_q        <= 1'b1;
      ack_q       <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shift_q     <= shift_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      tx_q        <= tx_d;
      ack_q       <= capture;
      if (capture) hold_q <= data_in;
    end
  end

  assign ack       = ack_q;
  assign Tx        = tx_q;
  assign busy      = (state_q != IDLE) || hold_full_q;
  assign frame_out = frame_q;

endmodule
